bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter sharing the single 8-bit memory/peripheral bus between the CPU and a second master (DMA engine or second core). Captures one-cycle read/write request pulses from each master, grants the bus round-robin, replays each request on the shared bus as a one-cycle pulse and returns a one-cycle ready pulse with read data to the owning master. Sits between the masters' bus ports and the memory/peripheral address decoder; each master keeps its existing read/write/ready protocol unchanged.

## Interface
- TIMEOUT, 255, bus cycles to wait for `bus_ready` before forced completion; 0 disables the watchdog (8-bit counter)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- m0_read / m1_read  in  1  one-cycle read request pulse from master 0 / 1
- m0_write / m1_write  in  1  one-cycle write request pulse from master 0 / 1
- m0_address / m1_address  in  8  request address, sampled with the pulse
- m0_data_out / m1_data_out  in  8  write data, sampled with the write pulse
- m0_ready / m1_ready  out  1  one-cycle completion pulse to master 0 / 1
- m0_data_in / m1_data_in  out  8  read data; valid with ready, held until the next read completion of that master
- bus_read / bus_write  out  1  one-cycle request pulse to the shared bus
- bus_address  out  8  registered shared-bus address
- bus_data_out  out  8  registered shared-bus write data
- bus_data_in  in  8  shared-bus read data, sampled with `bus_ready`
- bus_ready  in  1  shared-bus completion
- grant  out  2  one-hot current owner (2'b00 when idle)
- bus_err  out  1  sticky error flag

## Operation
- Per-master request buffer: pend, dir (0 read / 1 write), addr, data. Loaded on the edge sampling a read or write pulse while pend=0; cleared on that master's completion.
- Pulse while pend=1: dropped, bus_err set. read and write both high: dropped, bus_err set.
- States: IDLE, ISSUE, WAIT.
  - IDLE: no pend -> stay. One pend -> grant it. Both -> grant the master not granted last (last_grant resets to 1, so m0 wins the first tie). On grant: load bus_address/bus_data_out from that buffer, set grant, -> ISSUE.
  - ISSUE: bus_read or bus_write high (per dir) this cycle only. bus_ready=1 -> complete; else -> WAIT, clear watchdog.
  - WAIT: bus_ready=1 -> complete. Else watchdog increments; reaching TIMEOUT -> complete with read data 8'hFF, set bus_err.
- Complete: capture bus_data_in into the owner's data_in (reads only; writes leave it unchanged), pulse owner's ready next cycle, clear its pend, update last_grant, grant <= 2'b00, -> IDLE.
- A master may re-request in the cycle its ready is high; captured normally.
- Reset (any time, including mid-transaction): state IDLE, pend cleared, last_grant=1, watchdog 0; in-flight bus transaction abandoned, no ready issued.
- Reset values: all outputs 0 (ready, bus_read, bus_write, bus_address, bus_data_out, data_in, grant, bus_err).

## Timing
- Pulse sampled at edge E1; IDLE grants at E2; ISSUE (bus pulse) in cycle after E2; zero-wait slave (bus_ready during ISSUE) -> master ready high the cycle after E3. Minimum request-to-ready: 3 cycles.
- Each extra bus wait cycle adds one cycle.
- Back-to-back masters: second grant on the edge after completion; one dead IDLE cycle between bus pulses.
- bus_ready outside ISSUE/WAIT ignored.
- Timeout completion occurs on the edge where the counter reaches TIMEOUT, i.e. TIMEOUT cycles after entering WAIT.

## Structure
- Shared `type.v`: state encodings `arb_idle`, `arb_issue`, `arb_wait`; direction constants `arb_dir_read`, `arb_dir_write`; timeout read value 8'hFF.
- Sub-module `arb_port`: per-master request buffer (pend/dir/addr/data capture, overflow and read+write error detect, ready pulse and data_in hold), instantiated twice; arbiter FSM, watchdog and bus registers in `bus_arbiter`.

## Test plan
- m0 read 8'h10, slave returns 8'hA5 during ISSUE -> bus_read one cycle at addr 8'h10, m0_ready 3 cycles after pulse, m0_data_in=8'hA5, grant 2'b01 then 2'b00.
- m0 write 8'h3C to 8'h20 and m1 read 8'h21 same cycle -> m0 served first, m1 next; bus_write data 8'h3C; then simultaneous again -> m1 served first (round-robin).
- m1 read with slave 4 wait cycles -> m1_ready 4 cycles later than zero-wait case; m0_data_in unchanged.
- TIMEOUT=8, slave never responds -> m0_ready after 8 WAIT cycles, m0_data_in=8'hFF, bus_err=1 and stays 1.
- m0 second pulse while pending, and read+write together on m1 -> both dropped, bus_err=1, original m0 transaction completes normally.
- reset asserted during WAIT -> all outputs 0 immediately, no ready pulse; new request after release served normally.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    arb_idle  = 2'd0,
    arb_issue = 2'd1,
    arb_wait  = 2'd2
  } arb_state_e;

  localparam logic arb_dir_read  = 1'b0;
  localparam logic arb_dir_write = 1'b1;

  localparam logic [DATA_W-1:0] arb_timeout_data = 8'hFF;

  // last_grant: 0 = master 0 served last, 1 = master 1 served last.
  function automatic logic [1:0] pick_master(input logic pend0, input logic pend1,
                                             input logic last_grant);
    if (pend0 && pend1) return last_grant ? 2'b01 : 2'b10;
    if (pend0)          return 2'b01;
    if (pend1)          return 2'b10;
    return 2'b00;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side and shared-bus signals of the arbiter; master modport is the arbiter's view.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic              m0_read,  m0_write,  m0_ready;
  logic [ADDR_W-1:0] m0_address;
  logic [DATA_W-1:0] m0_data_out, m0_data_in;
  logic              m1_read,  m1_write,  m1_ready;
  logic [ADDR_W-1:0] m1_address;
  logic [DATA_W-1:0] m1_data_out, m1_data_in;
  logic              bus_read, bus_write, bus_ready;
  logic [ADDR_W-1:0] bus_address;
  logic [DATA_W-1:0] bus_data_out, bus_data_in;
  logic [1:0]        grant;
  logic              bus_err;

  modport master (
    input  m0_read, m0_write, m0_address, m0_data_out,
    input  m1_read, m1_write, m1_address, m1_data_out,
    input  bus_data_in, bus_ready,
    output m0_ready, m0_data_in, m1_ready, m1_data_in,
    output bus_read, bus_write, bus_address, bus_data_out, grant, bus_err
  );

  modport slave (
    output m0_read, m0_write, m0_address, m0_data_out,
    output m1_read, m1_write, m1_address, m1_data_out,
    output bus_data_in, bus_ready,
    input  m0_ready, m0_data_in, m1_ready, m1_data_in,
    input  bus_read, bus_write, bus_address, bus_data_out, grant, bus_err
  );

endinterface

// File: rtl/bus_arbiter_port.sv
// Per-master request buffer: captures one request, flags overflow/illegal pulses,
// returns the ready pulse and holds the last read data.
module arb_port
  import bus_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_out,
  input  logic              done,
  input  logic [DATA_W-1:0] done_data,
  output logic              pend,
  output logic              dir,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              ready,
  output logic [DATA_W-1:0] data_in,
  output logic              err
);

  logic              pend_q, pend_d, dir_q, dir_d, ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, data_in_q, data_in_d;

  always_comb begin
    pend_d    = pend_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    data_d    = data_q;
    data_in_d = data_in_q;
    ready_d   = done;
    err       = 1'b0;
    if (done) begin
      pend_d = 1'b0;
      if (dir_q == arb_dir_read) data_in_d = done_data;
    end
    // A pulse arriving on the completion edge still sees pend set and is dropped.
    if (read && write) begin
      err = 1'b1;
    end else if (read || write) begin
      if (pend_q) begin
        err = 1'b1;
      end else begin
        pend_d = 1'b1;
        dir_d  = write ? arb_dir_write : arb_dir_read;
        addr_d = address;
        data_d = data_out;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= 1'b0;
      dir_q     <= arb_dir_read;
      addr_q    <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      data_in_q <= '0;
    end else begin
      pend_q    <= pend_d;
      dir_q     <= dir_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      data_in_q <= data_in_d;
    end
  end

  assign pend    = pend_q;
  assign dir     = dir_q;
  assign addr    = addr_q;
  assign data    = data_q;
  assign ready   = ready_q;
  assign data_in = data_in_q;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter replaying buffered requests from two masters onto one shared bus,
// with a bus_ready watchdog that forces completion after TIMEOUT wait cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.master bif
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [7:0]        wdog_q, wdog_d;
  logic [1:0]        grant_q, grant_d;
  logic              bus_read_q, bus_read_d, bus_write_q, bus_write_d;
  logic [ADDR_W-1:0] bus_address_q, bus_address_d;
  logic [DATA_W-1:0] bus_data_out_q, bus_data_out_d;
  logic              bus_err_q, bus_err_d;

  logic              pend0, pend1, dir0, dir1, err0, err1, sel_dir, complete;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1, cpl_data;

  arb_port u_port0 (
    .clk(clk), .reset(reset),
    .read(bif.m0_read), .write(bif.m0_write), .address(bif.m0_address), .data_out(bif.m0_data_out),
    .done(complete && grant_q[0]), .done_data(cpl_data),
    .pend(pend0), .dir(dir0), .addr(addr0), .data(data0),
    .ready(bif.m0_ready), .data_in(bif.m0_data_in), .err(err0)
  );

  arb_port u_port1 (
    .clk(clk), .reset(reset),
    .read(bif.m1_read), .write(bif.m1_write), .address(bif.m1_address), .data_out(bif.m1_data_out),
    .done(complete && grant_q[1]), .done_data(cpl_data),
    .pend(pend1), .dir(dir1), .addr(addr1), .data(data1),
    .ready(bif.m1_ready), .data_in(bif.m1_data_in), .err(err1)
  );

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    wdog_d         = wdog_q;
    grant_d        = grant_q;
    bus_read_d     = 1'b0;
    bus_write_d    = 1'b0;
    bus_address_d  = bus_address_q;
    bus_data_out_d = bus_data_out_q;
    bus_err_d      = bus_err_q | err0 | err1;
    complete       = 1'b0;
    cpl_data       = bif.bus_data_in;
    sel_dir        = arb_dir_read;
    case (state_q)
      arb_idle: begin
        grant_d = pick_master(pend0, pend1, last_q);
        if (grant_d != 2'b00) begin
          sel_dir        = grant_d[1] ? dir1  : dir0;
          bus_address_d  = grant_d[1] ? addr1 : addr0;
          bus_data_out_d = grant_d[1] ? data1 : data0;
          bus_read_d     = (sel_dir == arb_dir_read);
          bus_write_d    = (sel_dir == arb_dir_write);
          state_d        = arb_issue;
        end
      end
      arb_issue: begin
        if (bif.bus_ready) begin
          complete = 1'b1;
        end else begin
          wdog_d  = 8'd0;
          state_d = arb_wait;
        end
      end
      arb_wait: begin
        if (bif.bus_ready) begin
          complete = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
          if (TIMEOUT != 0 && wdog_d == TIMEOUT_CNT) begin
            complete  = 1'b1;
            cpl_data  = arb_timeout_data;
            bus_err_d = 1'b1;
          end
        end
      end
      default: state_d = arb_idle;
    endcase
    if (complete) begin
      last_d  = grant_q[1];
      grant_d = 2'b00;
      state_d = arb_idle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= arb_idle;
      last_q         <= 1'b1;
      wdog_q         <= 8'd0;
      grant_q        <= 2'b00;
      bus_read_q     <= 1'b0;
      bus_write_q    <= 1'b0;
      bus_address_q  <= '0;
      bus_data_out_q <= '0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      wdog_q         <= wdog_d;
      grant_q        <= grant_d;
      bus_read_q     <= bus_read_d;
      bus_write_q    <= bus_write_d;
      bus_address_q  <= bus_address_d;
      bus_data_out_q <= bus_data_out_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign bif.bus_read     = bus_read_q;
  assign bif.bus_write    = bus_write_q;
  assign bif.bus_address  = bus_address_q;
  assign bif.bus_data_out = bus_data_out_q;
  assign bif.grant        = grant_q;
  assign bif.bus_err      = bus_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-scenario tasks with hand-computed cycle timing.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if bif ();
  bus_arbiter #(.TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bif(bif.master));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log and a simple slave answering each bus pulse after slv_lat cycles.
  int m0_rdy_cnt = 0, m1_rdy_cnt = 0, m0_rdy_cyc = -1, m1_rdy_cyc = -1, bus_cnt = 0;
  logic [7:0] last_addr = 8'h00, last_wdata = 8'h00;
  logic last_wr = 1'b0;
  int slv_lat = 0, slv_cnt = 0;
  bit slv_mute = 1'b0, slv_busy = 1'b0;
  logic [7:0] slv_data = 8'h00;

  always @(negedge clk) begin
    if (bif.m0_ready) begin m0_rdy_cnt++; m0_rdy_cyc = cyc; end
    if (bif.m1_ready) begin m1_rdy_cnt++; m1_rdy_cyc = cyc; end
    bif.bus_ready = 1'b0;
    if (bif.bus_read || bif.bus_write) begin
      bus_cnt++;
      last_addr = bif.bus_address; last_wdata = bif.bus_data_out; last_wr = bif.bus_write;
      slv_busy = 1'b1; slv_cnt = 0;
    end
    if (slv_mute) slv_busy = 1'b0;
    else if (slv_busy) begin
      if (slv_cnt == slv_lat) begin
        bif.bus_ready = 1'b1; bif.bus_data_in = slv_data; slv_busy = 1'b0;
      end else slv_cnt++;
    end
  end

  task automatic step();
    @(negedge clk); #1;
    bif.m0_read = 1'b0; bif.m0_write = 1'b0; bif.m1_read = 1'b0; bif.m1_write = 1'b0;
  endtask

  task automatic req(input bit m, input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    if (!m) begin bif.m0_read = rd; bif.m0_write = wr; bif.m0_address = a; bif.m0_data_out = d; end
    else    begin bif.m1_read = rd; bif.m1_write = wr; bif.m1_address = a; bif.m1_data_out = d; end
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0; step();
  endtask

  task automatic wait_cnt(input bit m, input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if ((m ? m1_rdy_cnt : m0_rdy_cnt) >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (bif.grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", bif.grant); end
    checks++; if ({bif.bus_read, bif.bus_write} !== 2'b00) begin errors++; $display("FAIL rst_bus_rw: got %b want 00", {bif.bus_read, bif.bus_write}); end
    checks++; if ({bif.bus_address, bif.bus_data_out} !== 16'h0000) begin errors++; $display("FAIL rst_bus_regs: got %h want 0000", {bif.bus_address, bif.bus_data_out}); end
    checks++; if ({bif.m0_ready, bif.m1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", {bif.m0_ready, bif.m1_ready}); end
    checks++; if ({bif.m0_data_in, bif.m1_data_in} !== 16'h0000) begin errors++; $display("FAIL rst_data_in: got %h want 0000", {bif.m0_data_in, bif.m1_data_in}); end
    checks++; if (bif.bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b want 0", bif.bus_err); end
    reset = 1'b0; step();
    checks++; if (bif.grant !== 2'b00) begin errors++; $display("FAIL rst_rel_grant: got %b want 00", bif.grant); end
  endtask

  task automatic test_single_read();
    int r, b0;
    slv_lat = 0; slv_data = 8'hA5; b0 = bus_cnt;
    req(0, 1, 0, 8'h10, 8'h00); r = cyc;
    step();
    checks++; if (bif.grant !== 2'b00) begin errors++; $display("FAIL rd_grant_e1: got %b want 00", bif.grant); end
    step();
    checks++; if (bif.grant !== 2'b01) begin errors++; $display("FAIL rd_grant: got %b want 01", bif.grant); end
    checks++; if (bif.bus_read !== 1'b1 || bif.bus_write !== 1'b0) begin errors++; $display("FAIL rd_bus_read: got rd=%b wr=%b want 1 0", bif.bus_read, bif.bus_write); end
    checks++; if (bif.bus_address !== 8'h10) begin errors++; $display("FAIL rd_bus_addr: got %h want 10", bif.bus_address); end
    step();
    checks++; if (bif.m0_ready !== 1'b1 || cyc != r + 3) begin errors++; $display("FAIL rd_ready: got %b at +%0d want 1 at +3", bif.m0_ready, cyc - r); end
    checks++; if (bif.m0_data_in !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h want a5", bif.m0_data_in); end
    checks++; if (bif.grant !== 2'b00 || bif.bus_read !== 1'b0) begin errors++; $display("FAIL rd_release: got grant=%b rd=%b want 00 0", bif.grant, bif.bus_read); end
    step();
    checks++; if (bif.m0_ready !== 1'b0 || bif.m0_data_in !== 8'hA5) begin errors++; $display("FAIL rd_hold: got rdy=%b data=%h want 0 a5", bif.m0_ready, bif.m0_data_in); end
    checks++; if (bus_cnt != b0 + 1) begin errors++; $display("FAIL rd_pulses: got %0d want 1", bus_cnt - b0); end
  endtask

  task automatic test_round_robin();
    int s, t, n0, n1;
    bit ok;
    do_reset();
    slv_lat = 0; slv_data = 8'h5A;
    req(0, 0, 1, 8'h20, 8'h3C); req(1, 1, 0, 8'h21, 8'h00);
    step(); step();
    checks++; if (bif.grant !== 2'b01 || bif.bus_write !== 1'b1) begin errors++; $display("FAIL rr_first: got grant=%b wr=%b want 01 1", bif.grant, bif.bus_write); end
    checks++; if (bif.bus_address !== 8'h20 || bif.bus_data_out !== 8'h3C) begin errors++; $display("FAIL rr_wdata: got %h/%h want 20/3c", bif.bus_address, bif.bus_data_out); end
    step();
    checks++; if (bif.m0_ready !== 1'b1 || bif.grant !== 2'b00 || {bif.bus_read, bif.bus_write} !== 2'b00) begin errors++; $display("FAIL rr_dead: got rdy=%b grant=%b rw=%b want 1 00 00", bif.m0_ready, bif.grant, {bif.bus_read, bif.bus_write}); end
    step();
    checks++; if (bif.grant !== 2'b10 || bif.bus_read !== 1'b1 || bif.bus_address !== 8'h21) begin errors++; $display("FAIL rr_second: got grant=%b rd=%b addr=%h want 10 1 21", bif.grant, bif.bus_read, bif.bus_address); end
    step();
    checks++; if (bif.m1_ready !== 1'b1 || bif.m1_data_in !== 8'h5A) begin errors++; $display("FAIL rr_m1_done: got rdy=%b data=%h want 1 5a", bif.m1_ready, bif.m1_data_in); end
    checks++; if (bif.m0_data_in !== 8'h00) begin errors++; $display("FAIL rr_wr_keeps_data: got %h want 00", bif.m0_data_in); end
    // m1 re-requests nothing; m0 alone moves last_grant to m0 so the next tie goes to m1.
    n0 = m0_rdy_cnt; req(0, 1, 0, 8'h22, 8'h00); s = cyc;
    wait_cnt(0, n0 + 1, ok);
    checks++; if (!ok || m0_rdy_cyc != s + 3) begin errors++; $display("FAIL rr_single: got ready at +%0d (ok=%b) want +3", m0_rdy_cyc - s, ok); end
    n0 = m0_rdy_cnt; n1 = m1_rdy_cnt;
    req(0, 1, 0, 8'h23, 8'h00); req(1, 1, 0, 8'h24, 8'h00); t = cyc;
    wait_cnt(0, n0 + 1, ok);
    checks++; if (!ok || m1_rdy_cnt != n1 + 1 || m1_rdy_cyc != t + 3) begin errors++; $display("FAIL rr_m1_wins: got m1 ready at +%0d want +3", m1_rdy_cyc - t); end
    checks++; if (m0_rdy_cyc != t + 5) begin errors++; $display("FAIL rr_m0_after: got m0 ready at +%0d want +5", m0_rdy_cyc - t); end
  endtask

  task automatic test_wait_states();
    int r, n1;
    bit ok;
    logic [7:0] m0_keep;
    slv_lat = 4; slv_data = 8'hC3; m0_keep = bif.m0_data_in; n1 = m1_rdy_cnt;
    req(1, 1, 0, 8'h40, 8'h00); r = cyc;
    wait_cnt(1, n1 + 1, ok);
    checks++; if (!ok || m1_rdy_cyc != r + 7) begin errors++; $display("FAIL ws_latency: got ready at +%0d (ok=%b) want +7", m1_rdy_cyc - r, ok); end
    checks++; if (bif.m1_data_in !== 8'hC3) begin errors++; $display("FAIL ws_data: got %h want c3", bif.m1_data_in); end
    checks++; if (bif.m0_data_in !== m0_keep) begin errors++; $display("FAIL ws_m0_data: got %h want %h", bif.m0_data_in, m0_keep); end
    checks++; if (last_addr !== 8'h40 || last_wr !== 1'b0) begin errors++; $display("FAIL ws_bus: got addr=%h wr=%b want 40 0", last_addr, last_wr); end
  endtask

  task automatic test_timeout();
    int r, n0;
    bit ok;
    slv_mute = 1'b1; n0 = m0_rdy_cnt;
    checks++; if (bif.bus_err !== 1'b0) begin errors++; $display("FAIL to_err_before: got %b want 0", bif.bus_err); end
    req(0, 1, 0, 8'h50, 8'h00); r = cyc;
    wait_cnt(0, n0 + 1, ok);
    checks++; if (!ok || m0_rdy_cyc != r + 11) begin errors++; $display("FAIL to_latency: got ready at +%0d (ok=%b) want +11", m0_rdy_cyc - r, ok); end
    checks++; if (bif.m0_data_in !== 8'hFF) begin errors++; $display("FAIL to_data: got %h want ff", bif.m0_data_in); end
    checks++; if (bif.bus_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", bif.bus_err); end
    step(); step(); step();
    checks++; if (bif.bus_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", bif.bus_err); end
    slv_mute = 1'b0;
  endtask

  task automatic test_errors();
    int r, n0, n1, b0;
    bit ok;
    do_reset();
    checks++; if (bif.bus_err !== 1'b0) begin errors++; $display("FAIL er_cleared: got %b want 0", bif.bus_err); end
    slv_lat = 2; slv_data = 8'h99; n0 = m0_rdy_cnt; n1 = m1_rdy_cnt; b0 = bus_cnt;
    req(0, 1, 0, 8'h60, 8'h00); r = cyc;
    step();
    req(0, 0, 1, 8'h61, 8'h11); req(1, 1, 1, 8'h62, 8'h22);
    step();
    checks++; if (bif.bus_err !== 1'b1) begin errors++; $display("FAIL er_flag: got %b want 1", bif.bus_err); end
    checks++; if (bif.grant !== 2'b01 || bif.bus_read !== 1'b1 || bif.bus_address !== 8'h60) begin errors++; $display("FAIL er_orig: got grant=%b rd=%b addr=%h want 01 1 60", bif.grant, bif.bus_read, bif.bus_address); end
    wait_cnt(0, n0 + 1, ok);
    checks++; if (!ok || m0_rdy_cyc != r + 5 || bif.m0_data_in !== 8'h99) begin errors++; $display("FAIL er_complete: got +%0d data=%h want +5 99", m0_rdy_cyc - r, bif.m0_data_in); end
    for (int i = 0; i < 6; i++) step();
    checks++; if (m1_rdy_cnt != n1 || bus_cnt != b0 + 1) begin errors++; $display("FAIL er_dropped: got m1 readies=%0d pulses=%0d want 0 1", m1_rdy_cnt - n1, bus_cnt - b0); end
  endtask

  task automatic test_reset_mid();
    int r, n1;
    bit ok;
    slv_mute = 1'b1;
    req(1, 1, 0, 8'h70, 8'h00);
    step(); step(); step(); step();
    checks++; if (bif.grant !== 2'b10) begin errors++; $display("FAIL rm_in_wait: got %b want 10", bif.grant); end
    n1 = m1_rdy_cnt;
    reset = 1'b1; #1;
    checks++; if (bif.grant !== 2'b00 || bif.bus_err !== 1'b0) begin errors++; $display("FAIL rm_async: got grant=%b err=%b want 00 0", bif.grant, bif.bus_err); end
    checks++; if (bif.m0_data_in !== 8'h00 || bif.bus_address !== 8'h00) begin errors++; $display("FAIL rm_regs: got data=%h addr=%h want 00 00", bif.m0_data_in, bif.bus_address); end
    step(); step(); reset = 1'b0; slv_mute = 1'b0; slv_lat = 0; slv_data = 8'h42;
    for (int i = 0; i < 12; i++) step();
    checks++; if (m1_rdy_cnt != n1) begin errors++; $display("FAIL rm_no_ready: got %0d readies want 0", m1_rdy_cnt - n1); end
    req(1, 1, 0, 8'h71, 8'h00); r = cyc;
    wait_cnt(1, n1 + 1, ok);
    checks++; if (!ok || m1_rdy_cyc != r + 3 || bif.m1_data_in !== 8'h42) begin errors++; $display("FAIL rm_after: got +%0d data=%h want +3 42", m1_rdy_cyc - r, bif.m1_data_in); end
  endtask

  initial begin
    bif.m0_read = 1'b0; bif.m0_write = 1'b0; bif.m0_address = 8'h00; bif.m0_data_out = 8'h00;
    bif.m1_read = 1'b0; bif.m1_write = 1'b0; bif.m1_address = 8'h00; bif.m1_data_out = 8'h00;
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
